// File: rtl/sample_sequencer_if.sv
// Signal bundle between the sample sequencer, the converter, the lowpass filter and the consumer.
// The slave modport is the sequencer's view; master is the environment driving it.
interface sample_sequencer_if;
   logic        enable;
   logic [17:0] adcdata;
   logic        endata;
   logic [17:0] filtin;
   logic [17:0] filtout;
   logic [17:0] dataout;
   logic        dvalid;
   logic        dready;
   logic        overflow;

   modport master (
      output enable, adcdata, filtout, dready,
      input  endata, filtin, dataout, dvalid, overflow
   );

   modport slave (
      input  enable, adcdata, filtout, dready,
      output endata, filtin, dataout, dvalid, overflow
   );
endinterface

// File: rtl/sample_sequencer.sv
// Paces a lowpass filter with periodic strobes, captures every DECIM-th filter result
// into a 4-entry FIFO and flags dropped results with a sticky overflow bit.
module sample_sequencer #(
   parameter int unsigned SAMPLE_PERIOD = 256,
   parameter int unsigned DECIM         = 4
) (
   input logic               clock,
   input logic               reset,
   sample_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

   localparam logic [9:0] CntLast = 10'(SAMPLE_PERIOD - 1);
   localparam logic [3:0] PhLast  = 4'(DECIM - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [9:0]  r_cnt;
   logic [3:0]  r_ph;
   logic        r_endata;
   logic [17:0] r_filtin;
   logic [17:0] r_mem [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic        r_overflow;

   logic        w_cnt_last;
   logic        w_active;
   logic        w_strobe;
   logic        w_capture;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_do_push;
   logic        w_dvalid;

   assign w_cnt_last = (r_cnt == CntLast);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (bus.enable) w_state_nxt = StPrime;
         end
         StPrime: begin
            if (!bus.enable)     w_state_nxt = StIdle;
            else if (w_cnt_last) w_state_nxt = StRun;
         end
         StRun: begin
            if (!bus.enable) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Dropping enable wins over a coincident strobe: the period is abandoned.
   always_comb begin
      w_active  = 1'b0;
      w_strobe  = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         StPrime: begin
            w_active = bus.enable;
            w_strobe = bus.enable && w_cnt_last;
         end
         StRun: begin
            w_active  = bus.enable;
            w_strobe  = bus.enable && w_cnt_last;
            w_capture = bus.enable && w_cnt_last;
         end
         default: ;
      endcase
   end

   // Idle (and the edge that enters PRIME) keeps both counters cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_ph  <= '0;
      end else if (!w_active) begin
         r_cnt <= '0;
         r_ph  <= '0;
      end else begin
         r_cnt <= w_strobe ? 10'd0 : r_cnt + 10'd1;
         if (w_capture) r_ph <= (r_ph == PhLast) ? 4'd0 : r_ph + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_endata <= 1'b0;
         r_filtin <= '0;
      end else begin
         r_endata <= w_strobe;
         if (w_strobe) r_filtin <= bus.adcdata;
      end
   end

   assign w_push    = w_capture && (r_ph == 4'd0);
   assign w_dvalid  = (r_count != 3'd0);
   assign w_full    = (r_count == 3'd4);
   assign w_pop     = w_dvalid && bus.dready;
   assign w_do_push = w_push && (!w_full || w_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= bus.filtout;
            r_wr_ptr        <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_do_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: ;
         endcase
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign bus.endata   = r_endata;
   assign bus.filtin   = r_filtin;
   assign bus.dvalid   = w_dvalid;
   assign bus.dataout  = w_dvalid ? r_mem[r_rd_ptr] : 18'd0;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench: instance a (period 8, decimate 2) and instance b (period 8, no decimation)
// run side by side from a shared reset; expectations are hand-derived per clock edge.
module tb_sample_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   sample_sequencer_if bus_a ();
   sample_sequencer_if bus_b ();

   sample_sequencer #(.SAMPLE_PERIOD(8), .DECIM(2)) u_dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   sample_sequencer #(.SAMPLE_PERIOD(8), .DECIM(1)) u_dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic        exp_en;
      logic        exp_dv;
      logic [17:0] exp_do;

      reset         = 1'b0;
      bus_a.enable  = 1'b0;
      bus_a.adcdata = '0;
      bus_a.filtout = '0;
      bus_a.dready  = 1'b0;
      bus_b.enable  = 1'b0;
      bus_b.adcdata = '0;
      bus_b.filtout = '0;
      bus_b.dready  = 1'b0;

      #1;
      chk("rst_endata",   {17'd0, bus_a.endata},   18'd0);
      chk("rst_filtin",   bus_a.filtin,            18'd0);
      chk("rst_dvalid",   {17'd0, bus_a.dvalid},   18'd0);
      chk("rst_dataout",  bus_a.dataout,           18'd0);
      chk("rst_overflow", {17'd0, bus_a.overflow}, 18'd0);

      repeat (2) @(negedge clock);
      reset         = 1'b1;
      bus_a.enable  = 1'b1;
      bus_a.adcdata = 18'h00123;
      bus_a.dready  = 1'b1;
      bus_b.enable  = 1'b1;
      bus_b.adcdata = 18'h2A5A5;
      bus_b.filtout = 18'd10;

      // The next rising edge is edge 0; each iteration observes the state after edge i.
      for (int i = 0; i <= 87; i++) begin
         @(negedge clock);

         exp_en = ((i % 8 == 0) && (i >= 8) && (i <= 48)) || (i == 79) || (i == 87);
         exp_dv = (i == 16) || (i == 32) || ((i >= 48) && (i <= 60)) || (i == 87);
         exp_do = (i == 16) ? 18'd1 : (i == 32) ? 18'd3 : (i == 87) ? 18'd77 : 18'd5;
         chk($sformatf("a_endata@%0d", i), {17'd0, bus_a.endata}, {17'd0, exp_en});
         chk($sformatf("a_dvalid@%0d", i), {17'd0, bus_a.dvalid}, {17'd0, exp_dv});
         if (exp_dv) chk($sformatf("a_dataout@%0d", i), bus_a.dataout, exp_do);
         if (i == 8 || i == 15) chk($sformatf("a_filtin@%0d", i), bus_a.filtin, 18'h00123);
         if (i == 16) chk("a_filtin@16", bus_a.filtin, 18'h3FFFF);
         if (i == 87) chk("a_overflow@87", {17'd0, bus_a.overflow}, 18'd0);

         case (i)
            8:  chk("b_filtin@8", bus_b.filtin, 18'h2A5A5);
            12: chk("b_dvalid_prime@12", {17'd0, bus_b.dvalid}, 18'd0);
            16: chk("b_dataout@16", bus_b.dataout, 18'd10);
            40: begin
               chk("b_dataout_full@40", bus_b.dataout, 18'd10);
               chk("b_overflow@40", {17'd0, bus_b.overflow}, 18'd0);
            end
            48: begin
               chk("b_dataout_pushpop@48", bus_b.dataout, 18'd11);
               chk("b_overflow_pushpop@48", {17'd0, bus_b.overflow}, 18'd0);
            end
            55: chk("b_overflow@55", {17'd0, bus_b.overflow}, 18'd0);
            56: begin
               chk("b_overflow_drop@56", {17'd0, bus_b.overflow}, 18'd1);
               chk("b_dataout@56", bus_b.dataout, 18'd11);
            end
            57: chk("b_dataout_pop@57", bus_b.dataout, 18'd12);
            87: begin
               chk("b_dvalid_hold@87", {17'd0, bus_b.dvalid}, 18'd1);
               chk("b_dataout_hold@87", bus_b.dataout, 18'd12);
               chk("b_overflow_sticky@87", {17'd0, bus_b.overflow}, 18'd1);
            end
            default: ;
         endcase

         // Stimulus for the following edge.
         if ((i % 8 == 0) && (i >= 8) && (i <= 48)) bus_a.filtout = 18'(i / 8);
         if ((i % 8 == 0) && (i >= 16)) bus_b.filtout = 18'(9 + i / 8);
         case (i)
            10: bus_a.adcdata = 18'h3FFFF;
            47: begin
               bus_a.dready = 1'b0;
               bus_b.dready = 1'b1;
            end
            48: bus_b.dready = 1'b0;
            53: bus_a.enable = 1'b0;
            56: begin
               bus_b.dready = 1'b1;
               bus_b.enable = 1'b0;
            end
            57: bus_b.dready = 1'b0;
            60: bus_a.dready = 1'b1;
            70: bus_a.enable = 1'b1;
            79: bus_a.filtout = 18'd77;
            default: ;
         endcase
      end

      // Asynchronous reset between edges while a has a strobe pending and b is full-ish.
      #2;
      reset = 1'b0;
      #1;
      chk("arst_a_endata",   {17'd0, bus_a.endata},   18'd0);
      chk("arst_a_filtin",   bus_a.filtin,            18'd0);
      chk("arst_a_dvalid",   {17'd0, bus_a.dvalid},   18'd0);
      chk("arst_a_dataout",  bus_a.dataout,           18'd0);
      chk("arst_b_dvalid",   {17'd0, bus_b.dvalid},   18'd0);
      chk("arst_b_dataout",  bus_b.dataout,           18'd0);
      chk("arst_b_overflow", {17'd0, bus_b.overflow}, 18'd0);
      chk("arst_b_filtin",   bus_b.filtin,            18'd0);
      @(posedge clock);
      #1;
      chk("arst_hold_a_endata", {17'd0, bus_a.endata}, 18'd0);
      chk("arst_hold_a_dvalid", {17'd0, bus_a.dvalid}, 18'd0);

      @(negedge clock);
      reset = 1'b1;
      for (int j = 0; j <= 8; j++) begin
         @(negedge clock);
         chk($sformatf("restart_a_endata@%0d", j), {17'd0, bus_a.endata}, {17'd0, j == 8});
      end
      chk("restart_a_filtin", bus_a.filtin, 18'h3FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 256, meaning clock cycles between filter input strobes; legal range 4..1023; the system value SHALL exceed the filter's per-sample computation time.
REQ-002 SHALL have parameter DECIM, default 4, meaning output decimation factor; legal range 1..16.
REQ-003 SHALL have port clock  input  1  master clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  master reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  run request; 1 = generate strobes, 0 = stop.
REQ-006 SHALL have port adcdata  input  18  raw sample from the converter interface.
REQ-007 SHALL have port endata  output  1  data clock enable to the lowpass filter, one-cycle pulse.
REQ-008 SHALL have port filtin  output  18  registered sample driving the filter's datain.
REQ-009 SHALL have port filtout  input  18  filter dataout, stable between strobes.
REQ-010 SHALL have port dataout  output  18  head entry of the output FIFO.
REQ-011 SHALL have port dvalid  output  1  FIFO non-empty.
REQ-012 SHALL have port dready  input  1  downstream accepts head when dvalid=1.
REQ-013 SHALL have port overflow  output  1  sticky flag, a decimated sample was dropped.

Function
REQ-014 SHALL implement states IDLE, PRIME, RUN; period counter cnt (10 bit); phase counter ph (4 bit); 4-entry FIFO.
REQ-015 IDLE: cnt=0, ph=0, no strobes; on edge sampling enable=1 -> PRIME, cnt=0.
REQ-016 PRIME/RUN: cnt increments every edge; on the edge where cnt==SAMPLE_PERIOD-1, cnt wraps to 0 (a "strobe edge").
REQ-017 At each strobe edge: endata<=1 for exactly one cycle, filtin<=adcdata; filtin SHALL otherwise hold.
REQ-018 First endata pulse SHALL be high in the cycle after the SAMPLE_PERIOD-th edge following the edge that sampled enable=1.
REQ-019 PRIME strobe edge: no capture (no filter result exists yet); -> RUN.
REQ-020 RUN strobe edge: filtout is the result of the previous strobe; if ph==0 push filtout into FIFO; ph<=(ph==DECIM-1)?0:ph+1.
REQ-021 Entering PRIME SHALL clear ph so the first RUN capture is pushed.
REQ-022 enable sampled 0 in PRIME or RUN -> IDLE on that edge, cnt=0, ph=0, endata<=0; FIFO contents and overflow preserved and still drainable.
REQ-023 FIFO: dvalid=1 iff count>0; dataout = head entry; pop on edge with dvalid&dready; no fall-through (pushed data visible after the push edge).
REQ-024 Push when count==4 and no pop: sample dropped, FIFO unchanged, overflow<=1; overflow clears only on reset.
REQ-025 Simultaneous push and pop with count==4: both performed, count stays 4, no overflow.
REQ-026 Simultaneous push and pop with count 1..3: count unchanged, order preserved.
REQ-027 dready while dvalid=0 SHALL have no effect; pointers wrap modulo 4.
REQ-028 No arithmetic on data: filtin, FIFO entries and dataout SHALL be bit-exact copies (18 bit, two's complement passed unmodified).

Reset
REQ-029 reset=0 SHALL immediately force: state IDLE, cnt=0, ph=0, endata=0, filtin=0, FIFO empty, dvalid=0, dataout=0, overflow=0.
REQ-030 Reset asserted mid-period or mid-drain SHALL abort with no further strobe or push; after release, operation restarts from IDLE.

Verification (SAMPLE_PERIOD=8, DECIM=2 unless stated)
REQ-031 enable=1 from edge 0, adcdata=18'h00123 -> endata high only after edges 8,16,24...; filtin=18'h00123 after edge 8.
REQ-032 filtout = strobe index k (1,2,3...), dready=1 -> pushes at RUN strobes 1,3,5 (filtout 1,3,5), dataout sequence 1,3,5, none of 2,4.
REQ-033 DECIM=1, dready=0, 6 RUN strobes with filtout 10..15 -> FIFO holds 10,11,12,13; overflow=1 after 5th push attempt; then dready=1 drains 10,11,12,13, dvalid=0.
REQ-034 FIFO full, dready=1 on a push edge -> head 10 popped, 14 accepted, count 4, overflow stays 0.
REQ-035 enable dropped at cnt=5 -> no endata at following edges; dvalid/dataout drain unaffected; re-enable -> next endata 8 edges later, first RUN capture pushed.
REQ-036 reset=0 asynchronously between edges with FIFO count 3, overflow=1 -> dvalid, dataout, overflow, endata, filtin all 0 before next edge.
